csi2tx_lane_distributor: RTL and testbench
==========================================

Name: csi2tx_lane_distributor

Overview:
- Parametrised byte-to-lane distributor for the CSI-2 TX HS path, in the txbyteclkhs domain between the packet builder and the D-PHY PPI.
- Takes a wide packet-byte stream and spreads it byte-round-robin across a runtime-selectable number of active data lanes (1/2/4/8).
- Drives per-lane txrequesths/txdatahs and obeys the per-lane txreadyhs handshake.
- Handles uneven lane end-of-packet and enforces a minimum HS gap between packets.

Parameters:
- MAX_LANES, 8, physical data lanes; power of two, 1..8.
- GAP_CYCLES, 4, minimum cycles with all txrequesths low between packets; must be at least 1.

Ports:
- txbyteclkhs  in  1  HS byte clock.
- txbyteclkhs_rst_n  in  1  asynchronous active-low reset.
- lane_cfg  in  2  log2 of active lane count; values above log2(MAX_LANES) clamp to MAX_LANES.
- in_valid  in  1  input beat valid.
- in_data  in  8*MAX_LANES  packet bytes; byte 0 is [7:0].
- in_last  in  1  final beat of packet.
- in_nbytes  in  clog2(MAX_LANES)+1  valid bytes on the last beat; ignored otherwise.
- in_ready  out  1  beat accepted when in_valid&in_ready.
- txreadyhs  in  MAX_LANES  PPI per-lane ready.
- txrequesths  out  MAX_LANES  PPI per-lane HS request.
- txdatahs  out  8*MAX_LANES  PPI lane bytes; lane i is [8i+7:8i].
- busy  out  1  high from packet acceptance through end of gap.
- underrun_err  out  1  starvation flag, high on each starved cycle.

Behaviour:
- Reset (asynchronous, immediate, also mid-packet):
  - txrequesths=0, txdatahs=0, in_ready=0, busy=0, underrun_err=0.
  - Beat buffer empty, state IDLE, gap counter 0.
  - First in_ready=1 comes one cycle after reset release.
- One-beat buffer plus slice index. N = active lanes. Slices per beat S = MAX_LANES/N. Slice s drives lane i (i<N) with buffer byte s*N+i. Lanes i>=N always have request=0 and data=0.
- States:
  - IDLE: in_ready=1. On accept, latch N from lane_cfg and the beat, then go to HS. lane_cfg is sampled only here; mid-packet changes are ignored.
  - HS: the request mask covers the lanes carrying valid bytes in the current slice. Advance occurs when (txreadyhs & txrequesths)==txrequesths. With no advance, data and requests hold.
  - GAP: all requests 0 for GAP_CYCLES cycles, then IDLE.
- Latency: a beat accepted at cycle t puts slice 0 on txrequesths/txdatahs at t+1.
- in_ready in HS is high only when the buffer holds a non-last beat and the final slice of that beat advances this cycle. This loads the next beat with zero bubbles.
- Last beat: nb = in_nbytes, with 0 or values >MAX_LANES treated as MAX_LANES.
  - Slices used: ceil(nb/N).
  - In the final slice, lane i requests only if s*N+i < nb. Other lanes drop request and drive data 0.
  - After that slice advances, enter GAP the next cycle.
- Underrun: the final slice of a non-last beat has advanced and in_valid is low.
  - Requests stay asserted and data holds the last slice.
  - underrun_err=1 on each such cycle where all requesting lanes are ready.
  - The new beat's slice 0 is presented the cycle after acceptance.
- busy=1 from the cycle after acceptance until the cycle GAP exits.

Decomposition:
- csi2tx_defines.v gets CSI2TX_MAX_LANES, CSI2TX_HS_GAP_CYCLES and the lane_cfg encodings (LANES_1=0, LANES_2=1, LANES_4=2, LANES_8=3).
- One combinational sub-module, csi2tx_lane_slicer. Inputs: beat buffer, N, slice index, last flag, nb. Outputs: txdatahs and the request mask.
- The FSM, slice counter and gap counter stay in the parent.

Test Plan (MAX_LANES=8, GAP_CYCLES=4, all txreadyhs=1 unless stated):
- Four-lane single beat: lane_cfg=2, one last beat, nbytes=8, bytes 00..07 -> txrequesths=0x0F for 2 cycles; lanes0-3 = 00,01,02,03 then 04,05,06,07; then 0x00 for exactly 4 cycles; busy falls; in_ready returns.
- Four-lane two beats: lane_cfg=2, two beats, second last with nbytes=3 -> 3 slices. Final slice: txrequesths=0x07, lane3 data 00. in_ready pulses on the first beat's final slice with no bubble.
- One-lane last beat: lane_cfg=0, last beat nbytes=5 -> lane0 carries 5 bytes over 5 cycles; txrequesths=0x01 throughout; other lanes 0.
- Eight-lane ready stall: lane_cfg=3, txreadyhs[5] low 3 cycles on slice 0 -> txdatahs/txrequesths=0xFF hold 3 extra cycles; no in_ready; advance when lane5 ready.
- Starvation: in_valid low 2 cycles between non-last beats -> underrun_err high 2 cycles; requests held; next beat appears the cycle after acceptance.
- Reset and config change: lane_cfg changed 4->1 mid-packet -> ignored; the next packet uses 1 lane. Reset asserted mid-HS -> all outputs 0 that cycle; the next packet after release starts clean.

Source files
------------

// File: rtl/csi2tx_lane_distributor_pkg.sv
// rtl/csi2tx_lane_distributor_pkg.sv - shared constants and helpers for the CSI-2 TX lane distributor
package csi2tx_lane_distributor_pkg;

  localparam int CSI2TX_MAX_LANES     = 8;
  localparam int CSI2TX_HS_GAP_CYCLES = 4;

  localparam logic [1:0] LANES_1 = 2'd0;
  localparam logic [1:0] LANES_2 = 2'd1;
  localparam logic [1:0] LANES_4 = 2'd2;
  localparam logic [1:0] LANES_8 = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HS   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Lane configurations wider than the physical lane count fall back to all lanes.
  function automatic logic [1:0] clamp_lane_cfg(input logic [1:0] cfg, input int max_lanes);
    int max_log;
    max_log = $clog2(max_lanes);
    return (int'(cfg) > max_log) ? 2'(max_log) : cfg;
  endfunction

endpackage

// File: rtl/csi2tx_lane_slicer.sv
// rtl/csi2tx_lane_slicer.sv - maps one slice of the beat buffer onto the active PPI lanes
module csi2tx_lane_slicer
  import csi2tx_lane_distributor_pkg::*;
#(
  parameter int  MAX_LANES = CSI2TX_MAX_LANES,
  localparam int SW        = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1,
  localparam int NBW       = $clog2(MAX_LANES) + 1
) (
  input  logic [8*MAX_LANES-1:0] beat,
  input  logic [1:0]             lane_log,
  input  logic [SW-1:0]          slice,
  input  logic                   last,
  input  logic [NBW-1:0]         nb,
  output logic [8*MAX_LANES-1:0] data,
  output logic [MAX_LANES-1:0]   mask
);

  int idx;

  always_comb begin
    data = '0;
    mask = '0;
    idx  = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      idx = (int'(slice) << lane_log) + i;
      // On the final beat only bytes below nb are real; the rest stay idle.
      if ((i < (1 << lane_log)) && (idx < MAX_LANES) && (!last || (idx < int'(nb)))) begin
        mask[i]          = 1'b1;
        data[8*i +: 8]   = beat[8*idx +: 8];
      end
    end
  end

endmodule

// File: rtl/csi2tx_lane_distributor.sv
// rtl/csi2tx_lane_distributor.sv - round-robin byte distributor from packet beats to D-PHY PPI lanes
module csi2tx_lane_distributor
  import csi2tx_lane_distributor_pkg::*;
#(
  parameter int  MAX_LANES  = CSI2TX_MAX_LANES,
  parameter int  GAP_CYCLES = CSI2TX_HS_GAP_CYCLES,
  localparam int SW         = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1,
  localparam int NBW        = $clog2(MAX_LANES) + 1,
  localparam int GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1
) (
  input  logic                   txbyteclkhs,
  input  logic                   txbyteclkhs_rst_n,
  input  logic [1:0]             lane_cfg,
  input  logic                   in_valid,
  input  logic [8*MAX_LANES-1:0] in_data,
  input  logic                   in_last,
  input  logic [NBW-1:0]         in_nbytes,
  output logic                   in_ready,
  input  logic [MAX_LANES-1:0]   txreadyhs,
  output logic [MAX_LANES-1:0]   txrequesths,
  output logic [8*MAX_LANES-1:0] txdatahs,
  output logic                   busy,
  output logic                   underrun_err
);

  logic [1:0]             state;
  logic                   ready_en;
  logic [8*MAX_LANES-1:0] beat;
  logic                   beat_last;
  logic [NBW-1:0]         beat_nb;
  logic [1:0]             lane_log;
  logic [SW-1:0]          slice;
  logic [GW-1:0]          gap_cnt;

  logic [MAX_LANES-1:0]   mask;
  logic [8*MAX_LANES-1:0] slice_data;
  logic [NBW-1:0]         nb_eff;
  logic                   advance;
  logic                   final_slice;
  logic                   accept;
  int                     slices;

  csi2tx_lane_slicer #(.MAX_LANES(MAX_LANES)) u_slicer (
    .beat     (beat),
    .lane_log (lane_log),
    .slice    (slice),
    .last     (beat_last),
    .nb       (beat_nb),
    .data     (slice_data),
    .mask     (mask)
  );

  always_comb begin
    nb_eff = ((in_nbytes == '0) || (int'(in_nbytes) > MAX_LANES)) ? NBW'(MAX_LANES) : in_nbytes;
    slices = beat_last ? ((int'(beat_nb) + (1 << lane_log) - 1) >> lane_log)
                       : (MAX_LANES >> lane_log);
    final_slice = (int'(slice) == (slices - 1));
    advance     = (state == ST_HS) && ((txreadyhs & mask) == mask);
    // Next beat is taken exactly as the current one drains, so no bubble appears on the lanes.
    in_ready    = ((state == ST_IDLE) && ready_en) || (advance && final_slice && !beat_last);
    accept      = in_valid && in_ready;
    txrequesths = (state == ST_HS) ? mask : '0;
    txdatahs    = (state == ST_HS) ? slice_data : '0;
    busy        = (state != ST_IDLE);
    underrun_err = advance && final_slice && !beat_last && !in_valid;
  end

  always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
    if (!txbyteclkhs_rst_n) begin
      state     <= ST_IDLE;
      ready_en  <= 1'b0;
      beat      <= '0;
      beat_last <= 1'b0;
      beat_nb   <= '0;
      lane_log  <= '0;
      slice     <= '0;
      gap_cnt   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        beat      <= in_data;
        beat_last <= in_last;
        beat_nb   <= nb_eff;
        slice     <= '0;
        state     <= ST_HS;
        if (state == ST_IDLE) begin
          lane_log <= clamp_lane_cfg(lane_cfg, MAX_LANES);
        end
      end else begin
        case (state)
          ST_HS: begin
            if (advance && !final_slice) begin
              slice <= slice + 1'b1;
            end else if (advance && beat_last) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end
          end
          ST_GAP: begin
            if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
              state <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          ST_IDLE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csi2tx_lane_distributor.sv
// tb/tb_csi2tx_lane_distributor.sv - scoreboard bench for the CSI-2 TX lane distributor
module tb_csi2tx_lane_distributor;

  localparam int ML = 8;
  localparam int G  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  lane_cfg = 2'd0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [3:0]  in_nbytes = '0;
  logic        in_ready;
  logic [7:0]  txreadyhs = '1;
  logic [7:0]  txrequesths;
  logic [63:0] txdatahs;
  logic        busy;
  logic        underrun_err;

  always #5 clk = ~clk;

  csi2tx_lane_distributor #(.MAX_LANES(ML), .GAP_CYCLES(G)) dut (
    .txbyteclkhs       (clk),
    .txbyteclkhs_rst_n (rst_n),
    .lane_cfg          (lane_cfg),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_last           (in_last),
    .in_nbytes         (in_nbytes),
    .in_ready          (in_ready),
    .txreadyhs         (txreadyhs),
    .txrequesths       (txrequesths),
    .txdatahs          (txdatahs),
    .busy              (busy),
    .underrun_err      (underrun_err)
  );

  typedef struct packed {
    logic [7:0]  mask;
    logic [63:0] data;
    logic        fin;
    logic        blast;
  } item_t;

  item_t exp_q[$];
  item_t held;
  bit    hold = 0;
  bit    mon_en = 0;
  bit    rnd_ready = 0;
  bit    acc_prev = 0;
  bit    gap_tail = 0;
  int    gap_left = 0;
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: byte k of a beat goes to lane k%n during transfer k/n; only the first nbe bytes exist.
  function automatic void model_beat(input logic [63:0] bytes, input int n, input bit last, input int nb);
    int nbe;
    int ns;
    nbe = !last ? ML : ((nb == 0 || nb > ML) ? ML : nb);
    ns  = (nbe + n - 1) / n;
    for (int s = 0; s < ns; s++) begin
      item_t it;
      it = '0;
      for (int i = 0; i < n; i++) begin
        int k;
        k = s * n + i;
        if (k < nbe) begin
          it.mask[i]        = 1'b1;
          it.data[8*i +: 8] = bytes[8*k +: 8];
        end
      end
      it.fin   = (s == ns - 1);
      it.blast = last;
      exp_q.push_back(it);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    txreadyhs = rnd_ready ? 8'($urandom | $urandom) : 8'hFF;
  end

  always @(negedge clk) begin
    bit    adv;
    bit    exp_ur;
    item_t cur;
    if (rst_n && mon_en) begin
      adv    = (txrequesths != 0) && ((txreadyhs & txrequesths) == txrequesths);
      exp_ur = 1'b0;
      if (acc_prev) begin
        if (exp_q.size() > 0) check("latency_slice0", 64'(txrequesths), 64'(exp_q[0].mask));
        else begin
          checks++; failures++;
          $display("FAIL latency_slice0 actual=%h required=scoreboard_entry", txrequesths);
        end
      end
      if (gap_left > 0) begin
        check("gap_requests", 64'(txrequesths), 64'(0));
        check("gap_busy", 64'(busy), 64'(1));
        gap_left--;
        if (gap_left == 0) gap_tail = 1;
      end else if (gap_tail) begin
        check("busy_after_gap", 64'(busy), 64'(0));
        check("ready_after_gap", 64'(in_ready), 64'(1));
        gap_tail = 0;
      end else if (adv) begin
        if (hold || exp_q.size() > 0) begin
          cur = hold ? held : exp_q.pop_front();
          check("lane_requests", 64'(txrequesths), 64'(cur.mask));
          check("lane_data", txdatahs, cur.data);
          exp_ur = cur.fin && !cur.blast && !in_valid;
          hold   = exp_ur;
          held   = cur;
          if (cur.fin && cur.blast) gap_left = G;
        end else begin
          checks++; failures++;
          $display("FAIL unexpected_transfer actual=%h required=none", txrequesths);
        end
      end
      check("underrun_err", 64'(underrun_err), 64'(exp_ur));
      acc_prev = in_valid && in_ready;
    end
  end

  task automatic wait_accept();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 500) begin
        $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
        $fatal(1, "accept timeout");
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input int cfg, input int nbeats, input int nb, input bit gaps);
    logic [63:0] bytes;
    lane_cfg = 2'(cfg);
    for (int b = 0; b < nbeats; b++) begin
      bytes = {$urandom, $urandom};
      model_beat(bytes, 1 << cfg, b == nbeats - 1, nb);
      in_valid  = 1'b1;
      in_data   = bytes;
      in_last   = (b == nbeats - 1);
      in_nbytes = (b == nbeats - 1) ? 4'(nb) : 4'($urandom);
      wait_accept();
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      lane_cfg = 2'($urandom);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 || hold || gap_left > 0 || gap_tail) begin
      @(posedge clk);
      t++;
      if (t > 2000) begin
        checks++; failures++;
        $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_requests", 64'(txrequesths), 64'(0));
    check("reset_data", txdatahs, 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_underrun", 64'(underrun_err), 64'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("ready_before_edge", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1 check("ready_after_release", 64'(in_ready), 64'(1));
    mon_en = 1;

    send_packet(2, 1, 8, 0);
    send_packet(2, 2, 3, 0);
    send_packet(0, 1, 5, 0);
    drain();
    rnd_ready = 1;
    send_packet(3, 1, 8, 0);
    rnd_ready = 0;
    send_packet(2, 3, 7, 1);
    drain();

    rnd_ready = 1;
    repeat (30) send_packet($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 15), 1);
    drain();

    rnd_ready = 0;
    mon_en    = 0;
    lane_cfg  = 2'd3;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom};
    in_last   = 1'b0;
    wait_accept();
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midhs_reset_requests", 64'(txrequesths), 64'(0));
    check("midhs_reset_data", txdatahs, 64'(0));
    check("midhs_reset_in_ready", 64'(in_ready), 64'(0));
    check("midhs_reset_busy", 64'(busy), 64'(0));
    exp_q.delete();
    hold = 0; gap_left = 0; gap_tail = 0; acc_prev = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;
    send_packet(2, 2, 6, 0);
    send_packet(0, 1, 3, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
